// File: rtl/abc_pipe_pkg.sv
// abc_pipe shared types: framer states, beat tag, stage-count helpers.
// Optional build macro: ABC_PIPE_FRAME_FILTER_EN.
package abc_pipe_pkg;

   localparam int ABC_PIPE_MAX_STAGES = 8;

   typedef enum logic {
      IDLE,
      PKT
   } abc_frame_state_t;

   typedef struct packed {
      logic sop;
      logic eop;
   } abc_tag_t;

   function automatic int abc_clamp_stages(int n);
      if (n < 1) return 1;
      if (n > ABC_PIPE_MAX_STAGES) return ABC_PIPE_MAX_STAGES;
      return n;
   endfunction

   function automatic logic abc_is_orphan(abc_frame_state_t st, logic sop);
      return (st == IDLE) && !sop;
   endfunction

endpackage

// File: rtl/abc_pipe_stage.sv
// One valid/ready register slice of the abc beat pipeline.
// mark_eop ORs a forced eop into whatever this slice holds after the edge.
module abc_pipe_stage
   import abc_pipe_pkg::*;
#(
   parameter int W = 64
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         up_valid,
   input  logic         up_sop,
   input  logic         up_eop,
   input  logic [W-1:0] up_data,
   input  logic         dn_ready,
   input  logic         mark_eop,
   output logic         valid,
   output logic         sop,
   output logic         eop,
   output logic [W-1:0] data
);

   typedef struct packed {
      abc_tag_t       tag;
      logic [W-1:0]   data;
   } beat_t;

   beat_t q;
   logic  ready;

   assign ready = !valid || dn_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= 1'b0;
         q     <= '0;
      end else begin
         if (ready) begin
            valid     <= up_valid;
            q.tag.sop <= up_sop;
            q.data    <= up_data;
         end
         q.tag.eop <= (ready ? up_eop : q.tag.eop) | mark_eop;
      end
   end

   assign sop  = q.tag.sop;
   assign eop  = q.tag.eop;
   assign data = q.data;

endmodule

// File: rtl/abc_pipe.sv
// Back-pressurable abc packet pipeline with framing checker and packet counter.
// Build macro ABC_PIPE_FRAME_FILTER_EN drops orphans and closes nested packets.
module abc_pipe
   import abc_pipe_pkg::*;
#(
   parameter int DATA_W = 64,
   parameter int STAGES = 2,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_sop,
   input  logic              in_eop,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_sop,
   output logic              out_eop,
   output logic [DATA_W-1:0] out_data,
   output logic              err_orphan,
   output logic              err_nested,
   output logic [CNT_W-1:0]  pkt_cnt
);

   localparam int NS = abc_clamp_stages(STAGES);

   abc_frame_state_t  state_q, state_d;
   logic [NS:0]       v, s, e;
   logic [DATA_W-1:0] d [NS+1];
   logic [NS-1:0]     dn_rdy, mark;
   logic              acc, orphan, nested, drop;

   assign acc    = in_valid && in_ready;
   assign orphan = acc && abc_is_orphan(state_q, in_sop);
   assign nested = acc && (state_q == PKT) && in_sop;

   assign v[0] = in_valid && !drop;
   assign s[0] = in_sop;
   assign e[0] = in_eop;
   assign d[0] = in_data;

   // ready of slice k+1, flattened so it depends only on valid bits
   for (genvar k = 0; k < NS; k++) begin : g_stage
      if (k == NS - 1) begin : g_last
         assign dn_rdy[k] = out_ready;
      end else begin : g_mid
         assign dn_rdy[k] = out_ready | ~&v[NS:k+2];
      end

      abc_pipe_stage #(.W(DATA_W)) u_stage (
         .clk      (clk),
         .rst_n    (rst_n),
         .up_valid (v[k]),
         .up_sop   (s[k]),
         .up_eop   (e[k]),
         .up_data  (d[k]),
         .dn_ready (dn_rdy[k]),
         .mark_eop (mark[k]),
         .valid    (v[k+1]),
         .sop      (s[k+1]),
         .eop      (e[k+1]),
         .data     (d[k+1])
      );
   end

   assign in_ready = !v[1] || dn_rdy[0];

`ifdef ABC_PIPE_FRAME_FILTER_EN
   logic [NS-1:0] young;

   assign drop = orphan;

   // youngest held beat either stays put or moves one slice down
   for (genvar k = 0; k < NS; k++) begin : g_mark
      if (k == 0) begin : g_first
         assign young[k] = v[1];
         assign mark[k]  = nested && young[k] && !dn_rdy[k];
      end else begin : g_rest
         assign young[k] = v[k+1] && ~|v[k:1];
         assign mark[k]  = nested &&
                           ((young[k] && !dn_rdy[k]) ||
                            (young[k-1] && dn_rdy[k-1]));
      end
   end
`else
   assign drop = 1'b0;
   assign mark = '0;
`endif

   always_comb begin
      state_d = state_q;
      if (acc) begin
         unique case (state_q)
            IDLE:    if (in_sop && !in_eop) state_d = PKT;
            PKT:     if (in_eop) state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         err_orphan <= 1'b0;
         err_nested <= 1'b0;
         pkt_cnt    <= '0;
      end else begin
         state_q    <= state_d;
         err_orphan <= orphan;
         err_nested <= nested;
         if (out_valid && out_ready && out_eop) pkt_cnt <= pkt_cnt + 1'b1;
      end
   end

   assign out_valid = v[NS];
   assign out_sop   = s[NS];
   assign out_eop   = e[NS];
   assign out_data  = d[NS];

endmodule

// File: tb/tb_abc_pipe.sv
// Self-checking bench for abc_pipe: vector table, scoreboard and corner sequences.
// Honours ABC_PIPE_FRAME_FILTER_EN when the build defines it.
module tb_abc_pipe;

   localparam int DW = 64;
   localparam int NS = 2;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic          in_sop = 1'b0;
   logic          in_eop = 1'b0;
   logic [DW-1:0] in_data = '0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic          out_sop;
   logic          out_eop;
   logic [DW-1:0] out_data;
   logic          err_orphan;
   logic          err_nested;
   logic [CW-1:0] pkt_cnt;

   abc_pipe #(.DATA_W(DW), .STAGES(NS), .CNT_W(CW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_sop     (in_sop),
      .in_eop     (in_eop),
      .in_data    (in_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_sop    (out_sop),
      .out_eop    (out_eop),
      .out_data   (out_data),
      .err_orphan (err_orphan),
      .err_nested (err_nested),
      .pkt_cnt    (pkt_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          sop;
      logic          eop;
      logic [DW-1:0] data;
      int            cyc;
   } sb_t;

   typedef struct {
      logic          sop;
      logic          eop;
      logic [DW-1:0] data;
      logic          exp_orphan;
      logic          exp_nested;
   } vec_t;

   sb_t           q[$];
   sb_t           ent;
   int            cyc = 0;
   int            n_chk = 0;
   int            n_fail = 0;
   bit            lat_chk = 0;
   bit            open_m = 0;
   bit            exp_orph = 0;
   bit            exp_nest = 0;
   bit            drop_m;
   logic [CW-1:0] cnt_m = '0;

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   assert property (@(posedge clk) disable iff (!rst_n)
      (in_valid && !in_ready) |=>
         (in_valid && $stable(in_sop) && $stable(in_eop) && $stable(in_data)));

   always @(posedge clk) cyc++;

   // scoreboard: checks first, then retire the leaving beat, then admit the new one
   always @(negedge clk) begin
      if (!rst_n) begin
         q.delete();
         open_m   = 0;
         exp_orph = 0;
         exp_nest = 0;
         cnt_m    = '0;
      end else begin
         chk("in_ready", in_ready, !(q.size() == NS && !out_ready));
         chk("pkt_cnt", pkt_cnt, cnt_m);
         chk("err_orphan", err_orphan, exp_orph);
         chk("err_nested", err_nested, exp_nest);
         exp_orph = 0;
         exp_nest = 0;
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               chk("out_extra", out_data, 64'hX);
            end else begin
               ent = q.pop_front();
               chk("out_data", out_data, ent.data);
               chk("out_sop", out_sop, ent.sop);
               chk("out_eop", out_eop, ent.eop);
               if (lat_chk) chk("latency", cyc - ent.cyc, NS);
               if (ent.eop) cnt_m = cnt_m + 1'b1;
            end
         end
         if (in_valid && in_ready) begin
            drop_m = 0;
            if (!open_m && !in_sop) exp_orph = 1;
            if (open_m && in_sop) exp_nest = 1;
`ifdef ABC_PIPE_FRAME_FILTER_EN
            if (!open_m && !in_sop) drop_m = 1;
            if (open_m && in_sop && q.size() > 0) begin
               ent = q[q.size()-1];
               ent.eop = 1'b1;
               q[q.size()-1] = ent;
            end
`endif
            if (!drop_m) q.push_back('{in_sop, in_eop, in_data, cyc});
            open_m = in_sop ? !in_eop : (open_m && !in_eop);
         end
      end
   end

   task automatic send(logic sop, logic eop, logic [DW-1:0] data);
      int w;
      in_valid = 1'b1;
      in_sop   = sop;
      in_eop   = eop;
      in_data  = data;
      w = 0;
      forever begin
         @(negedge clk);
         if (in_ready) break;
         w++;
         if (w > 100) begin
            chk("send_timeout", 0, 1);
            break;
         end
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic idle(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      idle(2);
      rst_n = 1'b1;
   endtask

   vec_t vt[8];

   initial begin
      vt[0] = '{1'b1, 1'b1, 64'h01,   1'b0, 1'b0};
      vt[1] = '{1'b1, 1'b0, 64'hA0,   1'b0, 1'b0};
      vt[2] = '{1'b0, 1'b0, 64'hA1,   1'b0, 1'b0};
      vt[3] = '{1'b1, 1'b0, 64'hB0,   1'b0, 1'b1};
      vt[4] = '{1'b0, 1'b1, 64'hB1,   1'b0, 1'b0};
      vt[5] = '{1'b0, 1'b0, 64'hDEAD, 1'b1, 1'b0};
      vt[6] = '{1'b0, 1'b1, 64'h77,   1'b1, 1'b0};
      vt[7] = '{1'b1, 1'b1, 64'h05,   1'b0, 1'b0};

      idle(3);
      rst_n = 1'b1;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_pkt_cnt", pkt_cnt, 0);
      chk("rst_err", {err_orphan, err_nested}, 0);

      lat_chk = 1;
      send(1, 0, 64'h11);
      send(0, 0, 64'h22);
      send(0, 0, 64'h33);
      send(0, 1, 64'h44);
      idle(5);
      lat_chk = 0;
      chk("pkt1_cnt", pkt_cnt, 1);

      fork
         for (int i = 0; i < 16; i++)
            send(i == 0, i == 15, 64'h100 + i);
         begin
            idle(5);
            out_ready = 1'b0;
            idle(5);
            out_ready = 1'b1;
         end
      join
      idle(6);
      chk("stream_cnt", pkt_cnt, 2);

      for (int i = 0; i < 8; i++) begin
         send(vt[i].sop, vt[i].eop, vt[i].data);
         chk($sformatf("vec%0d_orphan", i), err_orphan, vt[i].exp_orphan);
         chk($sformatf("vec%0d_nested", i), err_nested, vt[i].exp_nested);
      end
      idle(6);

      out_ready = 1'b0;
      send(1, 0, 64'h51);
      send(0, 0, 64'h52);
      #3;
      rst_n = 1'b0;
      #1;
      chk("async_out_valid", out_valid, 0);
      chk("async_pkt_cnt", pkt_cnt, 0);
      idle(1);
      rst_n = 1'b1;
      out_ready = 1'b1;
      chk("post_rst_ready", in_ready, 1);
      send(1, 0, 64'h61);
      chk("clean_sop", {err_orphan, err_nested}, 0);
      send(0, 1, 64'h62);
      idle(4);
      chk("clean_cnt", pkt_cnt, 1);
      do_reset();
      send(0, 0, 64'h60);
      chk("post_rst_orphan", err_orphan, 1);
      idle(4);

      do_reset();
      for (int i = 0; i < 17; i++) send(1, 1, 64'h200 + i);
      idle(5);
      chk("cnt_wrap", pkt_cnt, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
